axi_lite_initiator: RTL and testbench
=====================================

Name: axi_lite_initiator

Overview:
- AXI4-Lite manager (initiator) that turns a simple single-word request/response port from the Gameboy core into AXI4-Lite read or write transactions toward the Zynq PS slave port (e.g. cartridge ROM/RAM fetches in DDR).
- It complements the existing AXI target path, on which the PS is the manager.
- One transaction in flight at a time; the response is held until the core accepts it.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- TIMEOUT_CYCLES, 1024, cycles spent waiting in any AXI wait state before abort. Used only with the optional feature.

Ports:
- clock  input  1  system clock (FCLK_CLK0 domain)
- resetn  input  1  asynchronous, active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  initiator can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  write data
- req_wstrb  input  4  write byte strobes
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  32  read data (0 for writes)
- resp_err  output  1  1 = SLVERR/DECERR/timeout
- m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
- m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data channel
- m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
- m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
- m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data channel

Behaviour:
- Reset (async assert, sync release): state IDLE; all *valid, bready, rready, resp_valid, resp_err = 0; resp_rdata = 0; address and data registers = 0.
- req_ready = 1 only in IDLE (combinational from state).
- awprot = arprot = 3'b000.
- Addresses are registered with bits [1:0] forced to 0.
- IDLE:
  - On req_valid & req_ready, latch addr, wdata, wstrb and write flag.
  - Write → WR_REQ with awvalid = wvalid = 1 from the next cycle.
  - Read → RD_ADDR with arvalid = 1.
- WR_REQ:
  - awvalid drops the cycle after AW handshake; wvalid drops the cycle after W handshake, independently.
  - The two handshakes may occur in either order or the same cycle.
  - Once both are done → WR_RESP.
  - valid is never withdrawn before its handshake; address and data stay stable while valid.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture err = bresp[1], rdata = 0 → RESP.
- RD_ADDR: hold arvalid until arready; then → RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata and err = rresp[1] (rdata forwarded even on error) → RESP.
- RESP:
  - resp_valid = 1, outputs stable.
  - On resp_ready → IDLE.
  - The next request is accepted no earlier than the following cycle.
- Minimum latency: req handshake at cycle 0, AXI valid at cycle 1, zero-wait slave gives resp_valid at cycle 3.
- bvalid or rvalid arriving outside the matching wait state is ignored; the manager's ready stays low.
- resetn asserted mid-transaction: immediate abort, all outputs go to reset values, no response is issued.
- resp_rdata, resp_err hold their last values after leaving RESP; these values are don't-care for the core.

Optional Feature:
- Macro: AXI_INITIATOR_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on each state entry and increments in WR_REQ, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1, all AXI valid and ready outputs deassert and the block goes to RESP with resp_err = 1, resp_rdata = 0.
  - Any late AXI response is then ignored, as above.
- When undefined: no counter exists; the block waits indefinitely.

Test Plan:
- Read at 0x1000_0006, slave arready same cycle, rvalid next cycle, rdata = 0xDEADBEEF, rresp = 0 → araddr = 0x1000_0004; resp_rdata = 0xDEADBEEF, resp_err = 0; resp_valid 3 cycles after the req handshake.
- Write 0x12345678, wstrb = 4'b0011, wready 3 cycles before awready → each valid drops individually after its handshake; bvalid with bresp = 0 gives resp_err = 0, resp_rdata = 0.
- Read with rresp = 2'b10 and rdata = 0x55 → resp_err = 1, resp_rdata = 0x55. Write with bresp = 2'b11 → resp_err = 1.
- resp_ready held low 5 cycles → resp_valid and data stable, req_ready = 0; on the resp_ready pulse, IDLE the next cycle and a back-to-back request is accepted.
- resetn pulsed low during WR_REQ with awvalid = 1 → awvalid, wvalid and resp_valid are 0 the same cycle; after release, req_ready = 1 and no response is emitted.
- With AXI_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES = 16, arready held low → arvalid drops after 16 cycles; resp_valid = 1, resp_err = 1, resp_rdata = 0.

Source files
------------

// File: rtl/axi_lite_initiator_if.sv
// Bundle of the core request/response port and the AXI4-Lite manager channels.
// Every channel is valid/ready: a transfer occurs on a rising clock edge where both
// are high; once raised, valid stays high with stable payload until that transfer.
interface axi_lite_initiator_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );
endinterface

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite manager bridging the core's word request port to the PS.
// Optional wait-state abort is enabled with `define AXI_INITIATOR_TIMEOUT_EN.
module axi_lite_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                resetn,
  axi_lite_initiator_if.master bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Only the error bit of the response codes matters; addresses are word aligned.
  logic unused_bits;
  assign unused_bits = ^{bus.m_axi_bresp[0], bus.m_axi_rresp[0], bus.req_addr[1:0]};

`ifdef AXI_INITIATOR_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        in_wait, tmo_hit;

  assign in_wait = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                   (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
  assign tmo_hit = in_wait && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (bus.req_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently, in any order or together.
        aw_pend_d = aw_pend_q & ~bus.m_axi_awready;
        w_pend_d  = w_pend_q & ~bus.m_axi_wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.m_axi_bvalid) begin
          err_d   = bus.m_axi_bresp[1];
          rdata_d = 32'h0;
          state_d = S_RESP;
        end
      end
      S_RD_ADDR: begin
        if (bus.m_axi_arready) begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.m_axi_rvalid) begin
          err_d   = bus.m_axi_rresp[1];
          rdata_d = bus.m_axi_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AXI_INITIATOR_TIMEOUT_EN
    // A handshake completing on the final cycle still wins over the abort.
    if (tmo_hit && (state_d == state_q)) begin
      state_d   = S_RESP;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      err_d     = 1'b1;
      rdata_d   = 32'h0;
    end
    tmo_d = (state_d != state_q) ? 16'd0 : (in_wait ? tmo_q + 16'd1 : tmo_q);
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef AXI_INITIATOR_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Channel controls decode straight from state so an abort or reset drops them at once.
  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.resp_valid    = (state_q == S_RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;

  assign bus.m_axi_awvalid = aw_pend_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_wvalid  = w_pend_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_bready  = (state_q == S_WR_RESP);
  assign bus.m_axi_arvalid = (state_q == S_RD_ADDR);
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_rready  = (state_q == S_RD_DATA);

  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: core-side driver, delay-configurable AXI slave and a
// transaction-level model of the expected response and latency.
module tb_axi_lite_initiator;

  localparam int AW = 32;
`ifdef AXI_INITIATOR_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  axi_lite_initiator_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- core-side drive ----------------
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic [3:0]    req_wstrb = 4'h0;
  logic          resp_ready = 1'b0;

  assign bus.req_valid  = req_valid;
  assign bus.req_write  = req_write;
  assign bus.req_addr   = req_addr;
  assign bus.req_wdata  = req_wdata;
  assign bus.req_wstrb  = req_wstrb;
  assign bus.resp_ready = resp_ready;

  // ---------------- AXI slave ----------------
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  logic        sl_awready = 1'b0, sl_wready = 1'b0, sl_arready = 1'b0;
  logic        sl_bvalid = 1'b0, sl_rvalid = 1'b0;
  logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
  logic [31:0] sl_rdata = 32'h0;
  logic        inj_bvalid = 1'b0, inj_rvalid = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  assign bus.m_axi_awready = sl_awready;
  assign bus.m_axi_wready  = sl_wready;
  assign bus.m_axi_bvalid  = sl_bvalid | inj_bvalid;
  assign bus.m_axi_bresp   = sl_bresp;
  assign bus.m_axi_arready = sl_arready;
  assign bus.m_axi_rvalid  = sl_rvalid | inj_rvalid;
  assign bus.m_axi_rdata   = sl_rdata;
  assign bus.m_axi_rresp   = sl_rresp;

  always @(negedge clock) begin
    if (bus.m_axi_awvalid) begin
      if (aw_cnt >= cfg_aw_wait) sl_awready = 1'b1;
      else begin sl_awready = 1'b0; aw_cnt++; end
    end else begin
      sl_awready = 1'b0; aw_cnt = 0;
    end
    if (bus.m_axi_wvalid) begin
      if (w_cnt >= cfg_w_wait) sl_wready = 1'b1;
      else begin sl_wready = 1'b0; w_cnt++; end
    end else begin
      sl_wready = 1'b0; w_cnt = 0;
    end
    if (bus.m_axi_arvalid) begin
      if (ar_cnt >= cfg_ar_wait) sl_arready = 1'b1;
      else begin sl_arready = 1'b0; ar_cnt++; end
    end else begin
      sl_arready = 1'b0; ar_cnt = 0;
    end
    if (sl_bvalid) sl_bvalid = 1'b0;
    else if (bus.m_axi_bready) begin
      if (b_cnt >= cfg_b_wait) begin sl_bvalid = 1'b1; sl_bresp = cfg_bresp; b_cnt = 0; end
      else b_cnt++;
    end else b_cnt = 0;
    if (sl_rvalid) sl_rvalid = 1'b0;
    else if (bus.m_axi_rready) begin
      if (r_cnt >= cfg_r_wait) begin
        sl_rvalid = 1'b1; sl_rresp = cfg_rresp; sl_rdata = cfg_rdata; r_cnt = 0;
      end else r_cnt++;
    end else r_cnt = 0;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [32:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [32:0] model_resp(input logic wr, input logic tmo);
    if (tmo) return {1'b1, 32'h0};
    if (wr)  return {cfg_bresp[1], 32'h0};
    return {cfg_rresp[1], cfg_rdata};
  endfunction

  function automatic int exp_lat(input logic wr);
    if (wr) return 3 + ((cfg_aw_wait > cfg_w_wait) ? cfg_aw_wait : cfg_w_wait) + cfg_b_wait;
    return 3 + cfg_ar_wait + cfg_r_wait;
  endfunction

  typedef struct {
    int          lat;
    int          wait_n;
    int          aw_cyc;
    int          w_cyc;
    int          ar_cyc;
    int          ar_hi;
    logic [31:0] rdata;
    logic        err;
    int          viol;
    int          hold_viol;
    logic        post_ok;
  } obs_t;

  // ---------------- driver ----------------
  // Issues one request, records channel behaviour cycle by cycle, holds the response
  // for 'hold' cycles and then accepts it. Called at negedge+1, returns at negedge+1.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int hold, output obs_t o);
    logic [AW-1:0] ea;
    logic [2:0]    st0;
    bit            aw_done, w_done, ar_done;
    ea = {addr[AW-1:2], 2'b00};
    aw_done = 0; w_done = 0; ar_done = 0;
    o = '{lat:0, wait_n:0, aw_cyc:-1, w_cyc:-1, ar_cyc:-1, ar_hi:0, rdata:32'h0, err:1'b0,
          viol:0, hold_viol:0, post_ok:1'b0};
    while (bus.req_ready !== 1'b1 && o.wait_n < 100) begin
      @(negedge clock); #1; o.wait_n++;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(negedge clock); #1;
    req_valid = 1'b0; req_write = $urandom_range(0, 1);
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
    o.lat = 1;
    while (o.lat < 2000) begin
      if (bus.req_ready !== 1'b0) o.viol++;
      if (aw_done && bus.m_axi_awvalid !== 1'b0) o.viol++;
      if (w_done && bus.m_axi_wvalid !== 1'b0) o.viol++;
      if (ar_done && bus.m_axi_arvalid !== 1'b0) o.viol++;
      if (wr && !aw_done && !bus.resp_valid && bus.m_axi_awvalid !== 1'b1) o.viol++;
      if (wr && !w_done && !bus.resp_valid && bus.m_axi_wvalid !== 1'b1) o.viol++;
      if (!wr && !ar_done && !bus.resp_valid && bus.m_axi_arvalid !== 1'b1) o.viol++;
      if (!wr && bus.m_axi_bready !== 1'b0) o.viol++;
      if (wr && bus.m_axi_rready !== 1'b0) o.viol++;
      if (bus.m_axi_awvalid === 1'b1) begin
        if (!wr || bus.m_axi_awaddr !== ea) o.viol++;
        if (bus.m_axi_awready) begin aw_done = 1; o.aw_cyc = o.lat; end
      end
      if (bus.m_axi_wvalid === 1'b1) begin
        if (!wr || bus.m_axi_wdata !== wd || bus.m_axi_wstrb !== ws) o.viol++;
        if (bus.m_axi_wready) begin w_done = 1; o.w_cyc = o.lat; end
      end
      if (bus.m_axi_arvalid === 1'b1) begin
        o.ar_hi++;
        if (wr || bus.m_axi_araddr !== ea) o.viol++;
        if (bus.m_axi_arready) begin ar_done = 1; o.ar_cyc = o.lat; end
      end
      if (bus.resp_valid === 1'b1) break;
      @(negedge clock); #1; o.lat++;
    end
    if (bus.resp_valid !== 1'b1) begin
      o.viol++;
      $display("note: no response within %0d cycles", o.lat);
    end
    o.rdata = bus.resp_rdata;
    o.err   = bus.resp_err;
    st0     = dbg_state;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== o.rdata || bus.resp_err !== o.err ||
          bus.req_ready !== 1'b0 || dbg_state !== st0) o.hold_viol++;
    end
    resp_ready = 1'b1;
    @(negedge clock); #1;
    resp_ready = 1'b0;
    o.post_ok = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
         bus.m_axi_rready, bus.resp_valid, bus.resp_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.m_axi_awvalid, bus.m_axi_wvalid,
               bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready, bus.resp_valid, bus.resp_err});
    end
    n_cmp++;
    if (bus.resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata);
    end
    n_cmp++;
    if ({bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wdata, bus.m_axi_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got aw=%h ar=%h wd=%h ws=%h want all 0", bus.m_axi_awaddr,
               bus.m_axi_araddr, bus.m_axi_wdata, bus.m_axi_wstrb);
    end
    n_cmp++;
    if ({bus.m_axi_awprot, bus.m_axi_arprot} !== 6'b0) begin
      n_fail++; $display("FAIL prot: got %b/%b want 000/000", bus.m_axi_awprot, bus.m_axi_arprot);
    end
    @(negedge clock); #1;
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
    @(negedge clock); #1;
  endtask

  task automatic test_read_basic();
    obs_t o;
    logic [32:0] e;
    cfg_ar_wait = 0; cfg_r_wait = 0; cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    exp_q.push_back(model_resp(1'b0, 1'b0));
    run_txn(1'b0, 32'h1000_0006, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e) begin
      n_fail++; $display("FAIL read_resp: got err=%b data=%h want err=%b data=%h", o.err, o.rdata, e[32], e[31:0]);
    end
    n_cmp++;
    if (o.lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", o.lat); end
    n_cmp++;
    if (o.ar_cyc !== 1) begin n_fail++; $display("FAIL read_ar_cycle: got %0d want 1", o.ar_cyc); end
    n_cmp++;
    if (o.viol !== 0 || o.post_ok !== 1'b1) begin
      n_fail++; $display("FAIL read_protocol: got viol=%0d post=%b want 0/1", o.viol, o.post_ok);
    end
  endtask

  task automatic test_write_order();
    obs_t o;
    logic [32:0] e;
    cfg_aw_wait = 3; cfg_w_wait = 0; cfg_b_wait = 0; cfg_bresp = 2'b00;
    exp_q.push_back(model_resp(1'b1, 1'b0));
    run_txn(1'b1, 32'h2000_0013, 32'h12345678, 4'b0011, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e) begin
      n_fail++; $display("FAIL write_resp: got err=%b data=%h want err=%b data=%h", o.err, o.rdata, e[32], e[31:0]);
    end
    n_cmp++;
    if (o.w_cyc !== 1 || o.aw_cyc !== 4) begin
      n_fail++; $display("FAIL write_order: got w@%0d aw@%0d want w@1 aw@4", o.w_cyc, o.aw_cyc);
    end
    n_cmp++;
    if (o.lat !== exp_lat(1'b1)) begin
      n_fail++; $display("FAIL write_latency: got %0d want %0d", o.lat, exp_lat(1'b1));
    end
    n_cmp++;
    if (o.viol !== 0 || o.post_ok !== 1'b1) begin
      n_fail++; $display("FAIL write_protocol: got viol=%0d post=%b want 0/1", o.viol, o.post_ok);
    end
    cfg_aw_wait = 0;
  endtask

  task automatic test_errors();
    obs_t o;
    logic [32:0] e;
    cfg_rresp = 2'b10; cfg_rdata = 32'h0000_0055;
    exp_q.push_back(model_resp(1'b0, 1'b0));
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL read_slverr: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    cfg_bresp = 2'b11;
    exp_q.push_back(model_resp(1'b1, 1'b0));
    run_txn(1'b1, 32'h0000_0200, 32'hCAFEF00D, 4'hF, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL write_decerr: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    cfg_rresp = 2'b00; cfg_bresp = 2'b00;
  endtask

  task automatic test_resp_hold();
    obs_t o;
    logic [32:0] e;
    cfg_rdata = $urandom; cfg_rresp = 2'b00; cfg_r_wait = 1;
    exp_q.push_back(model_resp(1'b0, 1'b0));
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h0, 5, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e) begin
      n_fail++; $display("FAIL hold_resp: got err=%b data=%h want err=%b data=%h", o.err, o.rdata, e[32], e[31:0]);
    end
    n_cmp++;
    if (o.hold_viol !== 0) begin
      n_fail++; $display("FAIL hold_stable: got %0d unstable cycles want 0", o.hold_viol);
    end
    n_cmp++;
    if (o.post_ok !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got post_ok=%b want 1", o.post_ok);
    end
    cfg_r_wait = 0;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [32:0] e;
    cfg_bresp = 2'b01;
    exp_q.push_back(model_resp(1'b1, 1'b0));
    run_txn(1'b1, 32'h3000_000C, 32'hA5A5_5A5A, 4'b1100, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.wait_n !== 0) begin
      n_fail++; $display("FAIL b2b_accept: got %0d wait cycles want 0", o.wait_n);
    end
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL b2b_resp: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    cfg_bresp = 2'b00;
  endtask

  task automatic test_stray();
    obs_t o;
    logic [32:0] e;
    inj_bvalid = 1'b1; inj_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      n_cmp++;
      if ({bus.m_axi_bready, bus.m_axi_rready, bus.resp_valid, bus.req_ready} !== 4'b0001) begin
        n_fail++; $display("FAIL stray_idle: got br/rr/rv/qr=%b want 0001",
                           {bus.m_axi_bready, bus.m_axi_rready, bus.resp_valid, bus.req_ready});
      end
    end
    inj_rvalid = 1'b0;
    cfg_rdata = 32'h1357_9BDF;
    exp_q.push_back(model_resp(1'b0, 1'b0));
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL stray_b_in_read: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    inj_bvalid = 1'b0; inj_rvalid = 1'b1;
    exp_q.push_back(model_resp(1'b1, 1'b0));
    run_txn(1'b1, 32'h4000_0004, 32'h2468_ACE0, 4'hF, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL stray_r_in_write: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    inj_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    cfg_aw_wait = 100; cfg_w_wait = 100;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5000_0010;
    req_wdata = 32'h0BAD_F00D; req_wstrb = 4'hF;
    @(negedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock); #1;
    n_cmp++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre: got aw/w valid=%b want 11", {bus.m_axi_awvalid, bus.m_axi_wvalid});
    end
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.resp_valid, bus.m_axi_bready, bus.m_axi_arvalid} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_abort: got aw/w/rv/br/ar=%b want 00000",
                         {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.resp_valid, bus.m_axi_bready, bus.m_axi_arvalid});
    end
    @(negedge clock); #1;
    resetn = 1'b1;
    cfg_aw_wait = 0; cfg_w_wait = 0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (bus.resp_valid !== 1'b0 || bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL midrst_no_resp: got %0d cycles with activity want 0", bad);
    end
  endtask

`ifdef AXI_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    logic [32:0] e;
    cfg_ar_wait = 1000; cfg_rdata = 32'hFFFF_FFFF;
    exp_q.push_back(model_resp(1'b0, 1'b1));
    run_txn(1'b0, 32'h6000_0000, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e) begin
      n_fail++; $display("FAIL timeout_resp: got err=%b data=%h want err=%b data=%h", o.err, o.rdata, e[32], e[31:0]);
    end
    n_cmp++;
    if (o.ar_hi !== TMO || o.ar_cyc !== -1) begin
      n_fail++; $display("FAIL timeout_arvalid: got high %0d cycles (hs@%0d) want %0d (none)", o.ar_hi, o.ar_cyc, TMO);
    end
    n_cmp++;
    if (o.lat !== TMO + 1 || o.post_ok !== 1'b1) begin
      n_fail++; $display("FAIL timeout_latency: got %0d post=%b want %0d/1", o.lat, o.post_ok, TMO + 1);
    end
    cfg_ar_wait = 0;
  endtask
`else
  task automatic test_timeout();
    obs_t o;
    logic [32:0] e;
    cfg_ar_wait = 40; cfg_rdata = 32'h7777_0001;
    exp_q.push_back(model_resp(1'b0, 1'b0));
    run_txn(1'b0, 32'h6000_0000, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.err, o.rdata} !== e || o.viol !== 0) begin
      n_fail++; $display("FAIL long_wait_resp: got err=%b data=%h viol=%0d want err=%b data=%h", o.err, o.rdata, o.viol, e[32], e[31:0]);
    end
    n_cmp++;
    if (o.lat !== exp_lat(1'b0)) begin
      n_fail++; $display("FAIL long_wait_latency: got %0d want %0d", o.lat, exp_lat(1'b0));
    end
    cfg_ar_wait = 0;
  endtask
`endif

  task automatic test_random();
    obs_t        o;
    logic [32:0] e;
    logic        wr;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    for (int i = 0; i < 40; i++) begin
      wr   = $urandom_range(0, 1);
      addr = $urandom; wd = $urandom; ws = 4'($urandom_range(0, 15));
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_b_wait  = $urandom_range(0, 3); cfg_ar_wait = $urandom_range(0, 3);
      cfg_r_wait  = $urandom_range(0, 3);
      cfg_bresp   = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata   = $urandom;
      exp_q.push_back(model_resp(wr, 1'b0));
      run_txn(wr, addr, wd, ws, $urandom_range(0, 2), o);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o.err, o.rdata} !== e) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got err=%b data=%h want err=%b data=%h", i, o.err, o.rdata, e[32], e[31:0]);
      end
      n_cmp++;
      if (o.lat !== exp_lat(wr)) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, o.lat, exp_lat(wr));
      end
      n_cmp++;
      if (o.viol !== 0 || o.hold_viol !== 0 || o.post_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand_protocol[%0d]: got viol=%0d hold=%0d post=%b want 0/0/1", i, o.viol, o.hold_viol, o.post_ok);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_order();
    test_errors();
    test_resp_hold();
    test_back_to_back();
    test_stray();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
